// File: rtl/seqdet_pkg.sv
// Shared definitions for the serial sequence detector: FSM state encoding
// and the default alarm duration.
package seqdet_pkg;

    // S_FILL: history not yet full, no compare; S_RUN: compare every strobe
    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Buzzer on-time: 1 s at the 100 MHz system clock
    localparam int unsigned BUZZ_CYCLES_DEF = 100_000_000;

endpackage

// File: rtl/seq_detector_buzz_timer.sv
// Alarm timer for the sequence detector. A loadable down-counter whose
// width is derived from BUZZ_CYCLES; the buzzer is high while it is nonzero.
// load_i starts an idle alarm, reload_i restarts a running one to full.
module buzz_timer
    import seqdet_pkg::*;
#(
    parameter int unsigned BUZZ_CYCLES = BUZZ_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic reload_i,
    input  logic clear_i,
    output logic buzzer_o
);

    localparam int TW = $clog2(BUZZ_CYCLES + 1);
    localparam logic [TW-1:0] FULL = TW'(BUZZ_CYCLES);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Next timer value: clear beats load, load beats countdown
    always_comb begin
        timer_d = timer_q;
        if (clear_i) begin
            timer_d = '0;
        end else if (load_i || reload_i) begin
            timer_d = FULL;
        end else if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
        end
    end

    // Timer register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign buzzer_o = (timer_q != '0);

endmodule

// File: rtl/seq_detector.sv
// Serial sequence detector. Shifts in bit_in on each bit_valid strobe,
// compares the last PAT_LEN bits against PATTERN once the history is full,
// pulses hit, counts hits (saturating) and drives a timed buzzer.
// Build option: SEQDET_OVERLAP_EN defined keeps history after a match
// (overlapping detection); undefined restarts the fill after each match.
module seq_detector
    import seqdet_pkg::*;
#(
    parameter int unsigned         PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0]  PATTERN     = 4'b1110,
    parameter int unsigned         BUZZ_CYCLES = BUZZ_CYCLES_DEF,
    parameter int unsigned         CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic               clear,
    output logic [PAT_LEN-1:0] hist,
    output logic               hit,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic               buzzer
);

    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             state_q, state_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               hit_q, hit_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [PAT_LEN-1:0] shifted;
    logic               full_after;
    logic               match;
    logic               buzzer_w;

    assign shifted = {hist_q[PAT_LEN-2:0], bit_in};

    // Next-state logic: clear wins over a strobe; compare only on a full history
    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        hit_d      = 1'b0;
        hit_cnt_d  = hit_cnt_q;
        full_after = 1'b0;
        match      = 1'b0;
        if (clear) begin
            state_d = S_FILL;
            hist_d  = '0;
            fill_d  = '0;
        end else if (bit_valid) begin
            hist_d = shifted;
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FW'(1);
            end
            case (state_q)
                S_FILL:  full_after = (fill_q == FILL_FULL - FW'(1));
                S_RUN:   full_after = 1'b1;
                default: full_after = 1'b0;
            endcase
            if (full_after) begin
                state_d = S_RUN;
            end
            if (full_after && (shifted == PATTERN)) begin
                match = 1'b1;
                hit_d = 1'b1;
                if (hit_cnt_q != CNT_MAX) begin
                    hit_cnt_d = hit_cnt_q + CNT_W'(1);
                end
`ifdef SEQDET_OVERLAP_EN
                state_d = S_RUN;
`else
                // Non-overlapping: next match needs PAT_LEN fresh bits
                state_d = S_FILL;
                hist_d  = '0;
                fill_d  = '0;
`endif
            end
        end
    end

    // Detector state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FILL;
            hist_q    <= '0;
            fill_q    <= '0;
            hit_q     <= 1'b0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            hit_q     <= hit_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    buzz_timer #(
        .BUZZ_CYCLES(BUZZ_CYCLES)
    ) u_buzz_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (match && !buzzer_w),
        .reload_i(match && buzzer_w),
        .clear_i (clear),
        .buzzer_o(buzzer_w)
    );

    assign hist    = hist_q;
    assign hit     = hit_q;
    assign hit_cnt = hit_cnt_q;
    assign buzzer  = buzzer_w;

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector. Three instances share one stimulus
// stream: A (PATTERN 1110, CNT_W 2), B (PATTERN 1010), C (PATTERN 0000),
// all with BUZZ_CYCLES 16. A reference model tracks the received bit
// stream and the cycle of the last match for each instance.
module tb_seq_detector;

    localparam int BUZZ = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic clear = 1'b0;

    logic [3:0] hist_a, hist_b, hist_c;
    logic       hit_a, hit_b, hit_c;
    logic [1:0] cnt_a;
    logic [7:0] cnt_b, cnt_c;
    logic       buz_a, buz_b, buz_c;

    int errors = 0;
    int checks = 0;

    // reference model state, per instance
    int pat[3]    = '{14, 10, 0};
    int cntmax[3] = '{3, 255, 255};
    int seen[3];
    int val[3];
    int e_hit[3];
    int e_cnt[3];
    int armed[3];
    int last[3];
    int cyc = 0;

    always #5 clk = ~clk;

    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1110), .BUZZ_CYCLES(BUZZ), .CNT_W(2)) u_a (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .hist(hist_a), .hit(hit_a), .hit_cnt(cnt_a), .buzzer(buz_a));

    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1010), .BUZZ_CYCLES(BUZZ), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .hist(hist_b), .hit(hit_b), .hit_cnt(cnt_b), .buzzer(buz_b));

    seq_detector #(.PAT_LEN(4), .PATTERN(4'b0000), .BUZZ_CYCLES(BUZZ), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .hist(hist_c), .hit(hit_c), .hit_cnt(cnt_c), .buzzer(buz_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            seen[k] = 0; val[k] = 0; e_hit[k] = 0; e_cnt[k] = 0; armed[k] = 0; last[k] = 0;
        end
    endtask

    // one clock edge of the behavioural model
    task automatic model_edge(input logic bv, input logic b, input logic clr);
        cyc++;
        for (int k = 0; k < 3; k++) begin
            e_hit[k] = 0;
            if (clr) begin
                seen[k] = 0; val[k] = 0; armed[k] = 0;
            end else if (bv) begin
                val[k] = ((val[k] << 1) | int'(b)) & 15;
                if (seen[k] < 4) seen[k]++;
                if (seen[k] == 4 && val[k] == pat[k]) begin
                    e_hit[k] = 1;
                    if (e_cnt[k] < cntmax[k]) e_cnt[k]++;
                    armed[k] = 1;
                    last[k] = cyc;
`ifndef SEQDET_OVERLAP_EN
                    seen[k] = 0; val[k] = 0;
`endif
                end
            end
        end
    endtask

    function automatic int exp_buz(input int k);
        return (armed[k] != 0 && (cyc - last[k]) < BUZZ) ? 1 : 0;
    endfunction

    task automatic chk_inst(input int k, input logic [3:0] h, input logic ht,
                            input logic [7:0] c, input logic bz);
        chk($sformatf("dut%0d.hist", k), 32'(h), 32'(val[k]));
        chk($sformatf("dut%0d.hit", k), 32'(ht), 32'(e_hit[k]));
        chk($sformatf("dut%0d.hit_cnt", k), 32'(c), 32'(e_cnt[k]));
        chk($sformatf("dut%0d.buzzer", k), 32'(bz), 32'(exp_buz(k)));
    endtask

    task automatic chk_all();
        chk_inst(0, hist_a, hit_a, {6'd0, cnt_a}, buz_a);
        chk_inst(1, hist_b, hit_b, cnt_b, buz_b);
        chk_inst(2, hist_c, hit_c, cnt_c, buz_c);
    endtask

    task automatic step(input logic bv, input logic b, input logic clr);
        bit_valid = bv; bit_in = b; clear = clr;
        @(posedge clk);
        model_edge(bv, b, clr);
        #1;
        chk_all();
        bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
    endtask

    task automatic strobe_bit(input logic b);
        step(1'b1, b, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic strobe4(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) strobe_bit(bits[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk_all();
        #2 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk_all();
        #6 rst = 1'b0;

        // basic match and buzzer duration
        strobe4(4'b1110);
        idle(18);
        step(1'b0, 1'b0, 1'b1);

        // overlap behaviour on 1,0,1,0,1,0
        strobe4(4'b1010);
        strobe_bit(1'b1);
        strobe_bit(1'b0);
        step(1'b0, 1'b0, 1'b1);

        // fill guard for an all-zero pattern
        strobe4(4'b0000);
        step(1'b0, 1'b0, 1'b1);

        // clear collides with the completing strobe
        strobe_bit(1'b1); strobe_bit(1'b1); strobe_bit(1'b1);
        step(1'b1, 1'b0, 1'b1);
        idle(3);

        // async reset in the middle of an alarm
        strobe4(4'b1110);
        idle(5);
        async_reset();
        strobe_bit(1'b1); strobe_bit(1'b1); strobe_bit(1'b1);
        strobe_bit(1'b0);
        idle(2);

        // hit counter saturation with CNT_W=2 on instance A
        async_reset();
        for (int n = 0; n < 5; n++) begin
            strobe4(4'b1110);
            step(1'b0, 1'b0, 1'b1);
        end

        // second match 8 cycles into a running alarm
        strobe4(4'b1110);
        strobe4(4'b1110);
        idle(20);

        // randomized stream with occasional clears
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 60) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
